// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide memory port arbiter: load/store widths, MMIO base, FSM states.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int          ROB_SIZE_WIDTH = 3;
    localparam int          TAG_W_DEF      = ROB_SIZE_WIDTH + 1;
    localparam logic [31:0] IO_BASE_DEF    = 32'h0003_0000;

    // Load type encodings (bit 2 set = zero-extend)
    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    // Store width encodings
    localparam logic [1:0] ST_B = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } arb_state_e;

    // Transfer length in bytes; low two bits of load type and the store width share a layout.
    function automatic logic [2:0] xfer_len(input logic [1:0] w);
        case (w)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the three requester channels plus the byte-wide RAM/IO port.
// Latency: n/a (wires only).
// Backpressure: requests are held by the requester until the matching gnt pulse.
interface mem_arbiter_if #(
    parameter int TAG_W = mem_arbiter_pkg::TAG_W_DEF
) ();
    // RAM/IO port
    logic [7:0]       mem_din;
    logic [7:0]       mem_dout;
    logic [31:0]      mem_a;
    logic             mem_wr_out;
    // instruction fetch
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_gnt;
    logic             if_done;
    logic [31:0]      if_data;
    // load buffer
    logic             ld_req;
    logic [2:0]       ld_type;
    logic [31:0]      ld_addr;
    logic [TAG_W-1:0] ld_tag;
    logic             ld_gnt;
    logic             ld_done;
    logic [31:0]      ld_value;
    logic [TAG_W-1:0] ld_tag_out;
    // committed stores
    logic             st_req;
    logic [1:0]       st_width;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             st_gnt;
    logic             st_done;
    logic             busy_out;

    modport slave (
        input  mem_din, if_req, if_addr, ld_req, ld_type, ld_addr, ld_tag,
               st_req, st_width, st_addr, st_data,
        output mem_dout, mem_a, mem_wr_out, if_gnt, if_done, if_data,
               ld_gnt, ld_done, ld_value, ld_tag_out, st_gnt, st_done, busy_out
    );

    modport master (
        output mem_din, if_req, if_addr, ld_req, ld_type, ld_addr, ld_tag,
               st_req, st_width, st_addr, st_data,
        input  mem_dout, mem_a, mem_wr_out, if_gnt, if_done, if_data,
               ld_gnt, ld_done, ld_value, ld_tag_out, st_gnt, st_done, busy_out
    );
endinterface

// File: rtl/mem_byte_assembler.sv
// Collects read bytes little-endian into a word and sign/zero-extends it per load type.
// Latency: byte captured on the clock edge ending a cap_en_i cycle; value_o is combinational from the capture register.
// Backpressure: none; the arbiter withholds cap_en_i while stalled.
// Ports: clk_in/rst_in (async active-low), cap_en_i, cnt_i (1-based byte count, 4 wraps to 0),
//        ld_type_i, din_i (RAM byte), value_o (extended word).
module mem_byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cap_en_i,
    input  logic [1:0]  cnt_i,
    input  logic [2:0]  ld_type_i,
    input  logic [7:0]  din_i,
    output logic [31:0] value_o
);
    logic [31:0] bytes_q;
    logic [1:0]  idx;

    // Byte k arrives while the counter reads k+1.
    assign idx = cnt_i - 2'd1;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bytes_q <= '0;
        end else if (cap_en_i) begin
            case (idx)
                2'd0:    bytes_q[7:0]   <= din_i;
                2'd1:    bytes_q[15:8]  <= din_i;
                2'd2:    bytes_q[23:16] <= din_i;
                default: bytes_q[31:24] <= din_i;
            endcase
        end
    end

    // Stale upper bytes from earlier transfers are masked here.
    always_comb begin
        value_o = bytes_q;
        case (ld_type_i)
            LD_B:    value_o = {{24{bytes_q[7]}}, bytes_q[7:0]};
            LD_H:    value_o = {{16{bytes_q[15]}}, bytes_q[15:0]};
            LD_BU:   value_o = {24'd0, bytes_q[7:0]};
            LD_HU:   value_o = {16'd0, bytes_q[15:0]};
            default: value_o = bytes_q;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Owns the byte-wide RAM/IO port; fixed-priority arbitration st > ld > if, byte-serial transfers.
// Latency: read done n+1 cycles after grant (fetch 5); store done on last byte (n cycles after grant).
// Backpressure: requests held until gnt; rdy_in=0 freezes everything; MMIO stores wait on io_buffer_full_in.
// Ports: clk_in, rst_in (async active-low), rdy_in, need_flush_in, io_buffer_full_in, bus (slave side).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          TAG_W   = TAG_W_DEF,
    parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         need_flush_in,
    input  logic         io_buffer_full_in,
    mem_arbiter_if.slave bus
);
    arb_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       len_q, len_d;
    logic [2:0]       type_q, type_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             is_if_q, is_if_d;
    logic             cap_en;
    logic             rd_done;
    logic [31:0]      asm_value;
    logic [31:0]      st_shift;

    assign st_shift = data_q >> {cnt_q[1:0], 3'b000};

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        len_d           = len_q;
        type_d          = type_q;
        base_d          = base_q;
        data_d          = data_q;
        tag_d           = tag_q;
        is_if_d         = is_if_q;
        cap_en          = 1'b0;
        rd_done         = 1'b0;
        bus.if_gnt      = 1'b0;
        bus.ld_gnt      = 1'b0;
        bus.st_gnt      = 1'b0;
        bus.st_done     = 1'b0;
        bus.mem_a       = '0;
        bus.mem_dout    = '0;
        bus.mem_wr_out  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated by rst_in so a held request cannot leak a grant while in reset.
                if (rst_in && rdy_in) begin
                    if (bus.st_req) begin
                        // Stores are already committed, so a flush never holds them off.
                        bus.st_gnt = 1'b1;
                        bus.mem_a  = bus.st_addr;
                        state_d    = S_WRITE;
                        cnt_d      = 3'd0;
                        base_d     = bus.st_addr;
                        data_d     = bus.st_data;
                        len_d      = xfer_len(bus.st_width);
                    end else if (!need_flush_in && bus.ld_req) begin
                        bus.ld_gnt = 1'b1;
                        bus.mem_a  = bus.ld_addr;
                        state_d    = S_READ;
                        cnt_d      = 3'd1;
                        base_d     = bus.ld_addr;
                        type_d     = bus.ld_type;
                        tag_d      = bus.ld_tag;
                        is_if_d    = 1'b0;
                        len_d      = xfer_len(bus.ld_type[1:0]);
                    end else if (!need_flush_in && bus.if_req) begin
                        bus.if_gnt = 1'b1;
                        bus.mem_a  = bus.if_addr;
                        state_d    = S_READ;
                        cnt_d      = 3'd1;
                        base_d     = bus.if_addr;
                        type_d     = LD_W;
                        tag_d      = '1;
                        is_if_d    = 1'b1;
                        len_d      = 3'd4;
                    end
                end
            end

            S_READ: begin
                if (!rdy_in) begin
                    // Keep the not-yet-captured byte's address on the bus so mem_din
                    // holds that byte again on the first cycle after resume.
                    bus.mem_a = base_q + 32'(cnt_q) - 32'd1;
                end else begin
                    bus.mem_a = base_q + 32'(cnt_q);
                    if (need_flush_in) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        tag_d   = '1;
                    end else if (cnt_q > len_q) begin
                        rd_done = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cap_en  = 1'b1;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end

            S_WRITE: begin
                bus.mem_a    = base_q + 32'(cnt_q);
                bus.mem_dout = st_shift[7:0];
                if (rdy_in && !(base_q >= IO_BASE && io_buffer_full_in)) begin
                    bus.mem_wr_out = 1'b1;
                    if (cnt_q == len_q - 3'd1) begin
                        bus.st_done = 1'b1;
                        state_d     = S_IDLE;
                        cnt_d       = 3'd0;
                    end else begin
                        cnt_d       = cnt_q + 3'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            type_q  <= '0;
            base_q  <= '0;
            data_q  <= '0;
            tag_q   <= '1;
            is_if_q <= 1'b0;
        end else if (rdy_in) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            type_q  <= type_d;
            base_q  <= base_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            is_if_q <= is_if_d;
        end
    end

    mem_byte_assembler u_asm (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .cap_en_i  (cap_en),
        .cnt_i     (cnt_q[1:0]),
        .ld_type_i (type_q),
        .din_i     (bus.mem_din),
        .value_o   (asm_value)
    );

    assign bus.if_done    = rd_done & is_if_q;
    assign bus.ld_done    = rd_done & ~is_if_q;
    assign bus.if_data    = bus.if_done ? asm_value : '0;
    assign bus.ld_value   = bus.ld_done ? asm_value : '0;
    assign bus.ld_tag_out = bus.ld_done ? tag_q : '1;
    assign bus.busy_out   = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load/fetch vector table plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: exercises io_buffer_full_in, rdy_in stalls and flushes.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n, rdy, flush, io_full;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .rdy_in            (rdy),
        .need_flush_in     (flush),
        .io_buffer_full_in (io_full),
        .bus               (bus)
    );

    // 1 KiB RAM model, one-cycle read latency, addresses alias on the low 10 bits.
    logic [7:0] ram [0:1023];
    logic       pl_en = 1'b0;
    logic [9:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    int         wr_cnt = 0;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (bus.mem_wr_out) begin
            ram[bus.mem_a[9:0]] <= bus.mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
        bus.mem_din <= ram[bus.mem_a[9:0]];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a[9:0];
        pl_data = d;
        step();
        pl_en   = 1'b0;
    endtask

    typedef struct packed {
        logic        is_if;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] mem;   // byte k at mem[8k+7:8k]
        logic [3:0]  tag;
        logic [3:0]  lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input int idx, input vec_t v);
        int gk, dk;
        logic [31:0] val, a;
        logic [3:0]  tg;
        gk = -1; dk = -1; val = '0; tg = '0;
        for (int b = 0; b < 4; b++) begin
            a = v.addr + 32'(b);
            preload(a, v.mem[8*b +: 8]);
        end
        if (v.is_if) begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end else begin
            bus.ld_req = 1'b1; bus.ld_addr = v.addr; bus.ld_type = v.typ; bus.ld_tag = v.tag;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (gk < 0 && (v.is_if ? bus.if_gnt : bus.ld_gnt)) gk = k;
            if (dk < 0 && (v.is_if ? bus.if_done : bus.ld_done)) begin
                dk  = k;
                val = v.is_if ? bus.if_data : bus.ld_value;
                tg  = bus.ld_tag_out;
            end
            step();
            if (gk >= 0) begin bus.if_req = 1'b0; bus.ld_req = 1'b0; end
        end
        check($sformatf("vec%0d_gnt_cycle", idx), 32'(gk), 32'd0);
        check($sformatf("vec%0d_latency", idx), 32'(dk - gk), 32'(v.lat));
        check($sformatf("vec%0d_value", idx), val, v.exp);
        if (!v.is_if) check($sformatf("vec%0d_tag", idx), 32'(tg), 32'(v.tag));
    endtask

    int sg, sd, lg, ldn, ig, idn, nwr, ndone, w0;
    logic [31:0] lval, ival;

    initial begin
        vecs[0] = '{1'b0, LD_W,  32'h0000_0100, 32'h4433_2211, 4'd5, 4'd5, 32'h4433_2211};
        vecs[1] = '{1'b0, LD_B,  32'h0000_0200, 32'h5555_5580, 4'd3, 4'd2, 32'hFFFF_FF80};
        vecs[2] = '{1'b0, LD_BU, 32'h0000_0200, 32'h5555_5580, 4'd7, 4'd2, 32'h0000_0080};
        vecs[3] = '{1'b0, LD_H,  32'h0000_0300, 32'h5555_9234, 4'd1, 4'd3, 32'hFFFF_9234};
        vecs[4] = '{1'b0, LD_HU, 32'h0000_0300, 32'h5555_9234, 4'd2, 4'd3, 32'h0000_9234};
        vecs[5] = '{1'b0, LD_B,  32'h0000_0204, 32'hAAAA_AA7F, 4'd0, 4'd2, 32'h0000_007F};
        vecs[6] = '{1'b0, LD_W,  32'hFFFF_FFFE, 32'hD3C2_B1A0, 4'd6, 4'd5, 32'hD3C2_B1A0};
        vecs[7] = '{1'b1, LD_W,  32'h0000_0100, 32'h4433_2211, 4'd0, 4'd5, 32'h4433_2211};

        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ld_req = 1'b0; bus.ld_type = '0; bus.ld_addr = '0; bus.ld_tag = '0;
        bus.st_req = 1'b0; bus.st_width = '0; bus.st_addr = '0; bus.st_data = '0;

        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_busy",   32'(bus.busy_out),   32'd0);
        check("rst_wr",     32'(bus.mem_wr_out), 32'd0);
        check("rst_mem_a",  bus.mem_a,           32'd0);
        check("rst_tag",    32'(bus.ld_tag_out), 32'hF);
        check("rst_ldval",  bus.ld_value,        32'd0);
        check("rst_ifdata", bus.if_data,         32'd0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Priority: all three requesters at once
        preload(32'h200, 8'h80);
        sg = -1; sd = -1; lg = -1; ldn = -1; ig = -1; idn = -1; lval = '0; ival = '0;
        bus.st_req = 1'b1; bus.st_width = ST_W; bus.st_addr = 32'h10; bus.st_data = 32'hCAFE_F00D;
        bus.ld_req = 1'b1; bus.ld_type = LD_B; bus.ld_addr = 32'h200; bus.ld_tag = 4'd9;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (sg < 0 && bus.st_gnt)  sg = k;
            if (sd < 0 && bus.st_done) sd = k;
            if (lg < 0 && bus.ld_gnt)  lg = k;
            if (ldn < 0 && bus.ld_done) begin ldn = k; lval = bus.ld_value; end
            if (ig < 0 && bus.if_gnt)  ig = k;
            if (idn < 0 && bus.if_done) begin idn = k; ival = bus.if_data; end
            step();
            if (sg >= 0) bus.st_req = 1'b0;
            if (lg >= 0) bus.ld_req = 1'b0;
            if (ig >= 0) bus.if_req = 1'b0;
        end
        check("prio_st_gnt",  32'(sg),  32'd0);
        check("prio_st_done", 32'(sd),  32'd4);
        check("prio_ld_gnt",  32'(lg),  32'd5);
        check("prio_ld_done", 32'(ldn), 32'd7);
        check("prio_if_gnt",  32'(ig),  32'd8);
        check("prio_if_done", 32'(idn), 32'd13);
        check("prio_ld_val",  lval, 32'hFFFF_FF80);
        check("prio_if_val",  ival, 32'h4433_2211);
        check("prio_st_mem",  {ram[10'h13], ram[10'h12], ram[10'h11], ram[10'h10]}, 32'hCAFE_F00D);

        // MMIO store held off by a full UART buffer
        io_full = 1'b1; nwr = 0; sd = -1;
        bus.st_req = 1'b1; bus.st_width = ST_B; bus.st_addr = 32'h0003_0000; bus.st_data = 32'h0000_0041;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4 && bus.mem_wr_out) nwr++;
            if (sd < 0 && bus.st_done) sd = k;
            if (k == 4) begin
                check("io_wr",   32'(bus.mem_wr_out), 32'd1);
                check("io_addr", bus.mem_a, 32'h0003_0000);
                check("io_dout", 32'(bus.mem_dout), 32'h41);
            end
            if (k == 5) check("io_busy_after", 32'(bus.busy_out), 32'd0);
            step();
            if (k == 0) bus.st_req = 1'b0;
            if (k == 3) io_full = 1'b0;
        end
        check("io_held_writes", 32'(nwr), 32'd0);
        check("io_st_done",     32'(sd),  32'd4);

        // Flush in read cycle 2 of a fetch
        ndone = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (bus.if_done) ndone++;
            if (k == 2) check("flush_busy_c2", 32'(bus.busy_out), 32'd1);
            if (k == 3) check("flush_busy_c3", 32'(bus.busy_out), 32'd0);
            step();
            if (k == 0) bus.if_req = 1'b0;
            flush = (k == 1);
        end
        check("flush_no_if_done", 32'(ndone), 32'd0);

        // Flush in IDLE blocks a load grant for that cycle only
        lg = -1; ldn = -1; lval = '0;
        flush = 1'b1;
        bus.ld_req = 1'b1; bus.ld_type = LD_B; bus.ld_addr = 32'h200; bus.ld_tag = 4'd5;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (lg < 0 && bus.ld_gnt) lg = k;
            if (ldn < 0 && bus.ld_done) begin ldn = k; lval = bus.ld_value; end
            step();
            flush = 1'b0;
            if (lg >= 0) bus.ld_req = 1'b0;
        end
        check("flush_ld_gnt",  32'(lg),  32'd1);
        check("flush_ld_done", 32'(ldn), 32'd3);
        check("flush_ld_val",  lval, 32'hFFFF_FF80);

        // Flush throughout a word store: grant and all bytes proceed
        w0 = wr_cnt; sg = -1; sd = -1;
        flush = 1'b1;
        bus.st_req = 1'b1; bus.st_width = ST_W; bus.st_addr = 32'h40; bus.st_data = 32'hA1B2_C3D4;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (sg < 0 && bus.st_gnt)  sg = k;
            if (sd < 0 && bus.st_done) sd = k;
            step();
            if (sg >= 0) bus.st_req = 1'b0;
        end
        flush = 1'b0;
        check("flush_st_gnt",  32'(sg), 32'd0);
        check("flush_st_done", 32'(sd), 32'd4);
        check("flush_st_nwr",  32'(wr_cnt - w0), 32'd4);
        check("flush_st_mem",  {ram[10'h43], ram[10'h42], ram[10'h41], ram[10'h40]}, 32'hA1B2_C3D4);

        // rdy_in low two cycles in the middle of LH
        ldn = -1; lval = '0;
        bus.ld_req = 1'b1; bus.ld_type = LD_H; bus.ld_addr = 32'h300; bus.ld_tag = 4'd4;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ldn < 0 && bus.ld_done) begin ldn = k; lval = bus.ld_value; w0 = 32'(bus.ld_tag_out); end
            step();
            if (k == 0) bus.ld_req = 1'b0;
            rdy = !(k == 1 || k == 2);
        end
        check("stall_ld_done", 32'(ldn), 32'd5);
        check("stall_ld_val",  lval, 32'hFFFF_9234);
        check("stall_ld_tag",  32'(w0), 32'd4);

        // Asynchronous reset in the middle of a word store
        bus.st_req = 1'b1; bus.st_width = ST_W; bus.st_addr = 32'h50; bus.st_data = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) check("arst_pre_wr", 32'(bus.mem_wr_out), 32'd1);
            if (k < 2) begin
                step();
                bus.st_req = 1'b0;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr",    32'(bus.mem_wr_out), 32'd0);
        check("arst_busy",  32'(bus.busy_out),   32'd0);
        check("arst_mem_a", bus.mem_a,           32'd0);
        check("arst_done",  32'(bus.st_done),    32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
